// File: rtl/fibonacci_lfsr_64_checker_pkg.sv
// Shared definitions for the 64-bit Fibonacci LFSR checker and its matching generator.
// Both ends take their tap set from here so they cannot drift apart.
package fibonacci_lfsr_64_checker_pkg;

  localparam int unsigned LFSR_W   = 64;
  localparam int unsigned NUM_TAPS = 4;
  // History bit indices for taps 64,63,61,60 (c[0] is the newest bit)
  localparam int unsigned LFSR_TAPS [NUM_TAPS] = '{63, 62, 60, 59};
  localparam int unsigned FILL_W   = 7;

  typedef enum logic [1:0] {
    StAcquire = 2'd0,
    StVerify  = 2'd1,
    StLocked  = 2'd2
  } state_e;

endpackage

// File: rtl/fibonacci_lfsr_64_feedback.sv
// Combinational feedback/prediction bit of the 64-bit Fibonacci LFSR.
// Reusable by the generator: o_p is the next bit the register produces.
module fibonacci_lfsr_64_feedback
  import fibonacci_lfsr_64_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] i_c,
  output logic              o_p
);

  always_comb begin
    o_p = 1'b0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      o_p = o_p ^ i_c[LFSR_TAPS[i][5:0]];
    end
  end

endmodule

// File: rtl/fibonacci_lfsr_64_checker.sv
// Serial checker for a 64-bit Fibonacci LFSR stream: fills a history register,
// verifies a run of predicted bits, then free-runs and counts mismatches while locked.
module fibonacci_lfsr_64_checker
  import fibonacci_lfsr_64_checker_pkg::*;
#(
  parameter int unsigned LOCK_GOOD = 16,
  parameter int unsigned LOSS_ERRS = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic [1:0]       state
);

  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned ERR_W  = $clog2(LOSS_ERRS + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(LOSS_ERRS - 1);

  state_e              r_state, w_state_d;
  logic [LFSR_W-1:0]   r_c, w_c_d;
  logic [FILL_W-1:0]   r_fill, w_fill_d;
  logic [GOOD_W-1:0]   r_good, w_good_d;
  logic [ERR_W-1:0]    r_cerr, w_cerr_d;
  logic                r_locked, w_locked_d;
  logic                r_err, w_err_d;
  logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_d;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_d;
  logic                w_p;

  fibonacci_lfsr_64_feedback u_feedback (
    .i_c (r_c),
    .o_p (w_p)
  );

  always_comb begin
    w_state_d   = r_state;
    w_c_d       = r_c;
    w_fill_d    = r_fill;
    w_good_d    = r_good;
    w_cerr_d    = r_cerr;
    w_err_d     = 1'b0;
    w_err_cnt_d = r_err_cnt;
    w_bit_cnt_d = r_bit_cnt;
    case (r_state)
      StAcquire: if (in_valid) begin
        w_c_d = {r_c[LFSR_W-2:0], in_bit};
        if (r_fill == FILL_LAST) begin
          w_state_d = StVerify;
          w_fill_d  = '0;
          w_good_d  = '0;
        end else begin
          w_fill_d = r_fill + 1'b1;
        end
      end
      StVerify: if (in_valid) begin
        w_c_d = {r_c[LFSR_W-2:0], in_bit};
        if (in_bit == w_p) begin
          if (r_good == GOOD_LAST) begin
            w_state_d = StLocked;
            w_good_d  = '0;
            w_cerr_d  = '0;
          end else begin
            w_good_d = r_good + 1'b1;
          end
        end else begin
          // The offending bit is already in the history, so it counts as fill
          w_state_d = StAcquire;
          w_fill_d  = FILL_W'(1);
          w_good_d  = '0;
        end
      end
      StLocked: if (in_valid) begin
        // Free-run on the prediction so line errors never pollute the history
        w_c_d = {r_c[LFSR_W-2:0], w_p};
        if (r_bit_cnt != '1) w_bit_cnt_d = r_bit_cnt + 1'b1;
        if (in_bit != w_p) begin
          w_err_d = 1'b1;
          if (r_err_cnt != '1) w_err_cnt_d = r_err_cnt + 1'b1;
          if (r_cerr == ERR_LAST) begin
            w_state_d = StAcquire;
            w_fill_d  = '0;
            w_cerr_d  = '0;
          end else begin
            w_cerr_d = r_cerr + 1'b1;
          end
        end else begin
          w_cerr_d = '0;
        end
      end
      default: begin
        w_state_d = StAcquire;
        w_fill_d  = '0;
        w_good_d  = '0;
        w_cerr_d  = '0;
      end
    endcase
    if (clr_cnt) begin
      w_err_cnt_d = '0;
      w_bit_cnt_d = '0;
    end
    w_locked_d = (w_state_d == StLocked);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StAcquire;
      r_c       <= '0;
      r_fill    <= '0;
      r_good    <= '0;
      r_cerr    <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_c       <= w_c_d;
      r_fill    <= w_fill_d;
      r_good    <= w_good_d;
      r_cerr    <= w_cerr_d;
      r_locked  <= w_locked_d;
      r_err     <= w_err_d;
      r_err_cnt <= w_err_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_cnt;
  assign bit_count = r_bit_cnt;
  assign state     = r_state;

endmodule
